// File: rtl/arbiter_nm_slave.sv
// Round-robin arbiter that lets N masters share one slave port. Each grant runs
// IDLE -> BUSY -> DONE, and an ack timeout keeps a dead slave from hanging a master.
module arbiter_nm_slave #(
  parameter int N_MASTERS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 16,
  localparam int BE_W     = DATA_W / 8,
  localparam int ID_W     = (N_MASTERS > 2) ? $clog2(N_MASTERS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS*BE_W-1:0] m_be,
  input  logic [N_MASTERS-1:0]      m_wr,
  input  logic [N_MASTERS-1:0]      m_rd,
  input  logic [N_MASTERS*DATA_W-1:0] m_dwr,
  output logic [N_MASTERS*DATA_W-1:0] m_drd,
  output logic [N_MASTERS-1:0]      m_ack,
  output logic [N_MASTERS-1:0]      m_err,
  output logic [ADDR_W-1:0]         addr_general,
  output logic [BE_W-1:0]           be_general,
  output logic                      wr_general,
  output logic                      rd_general,
  output logic [DATA_W-1:0]         dwr_general,
  input  logic [DATA_W-1:0]         drd_general,
  input  logic                      ack_slave,
  output logic [ID_W-1:0]           cpu_general,
  output logic [1:0]                dbg_state
);
  // Handshake: master i raises m_wr[i]/m_rd[i] with addr/be/dwr and holds all of them
  // stable until its one-cycle m_ack[i]; it drops the request the cycle after. On the
  // slave side wr_general/rd_general stay high until ack_slave or the timeout.

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [N_MASTERS-1:0] req;
  logic             found;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  last_grant;
  logic [CNT_W-1:0] cnt;
  logic             expired;

  assign req       = m_wr | m_rd;
  assign expired   = (cnt == CNT_W'(TIMEOUT - 1));
  assign dbg_state = state;

  // The search starts one past the previous winner, so every requester is served
  // within N_MASTERS grants.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand = ID_W'((int'(last_grant) + k) % N_MASTERS);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = BUSY;
      BUSY:    if (ack_slave || expired) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_drd        <= '0;
      m_ack        <= '0;
      m_err        <= '0;
      addr_general <= '0;
      be_general   <= '0;
      wr_general   <= 1'b0;
      rd_general   <= 1'b0;
      dwr_general  <= '0;
      cpu_general  <= '0;
      cnt          <= '0;
      last_grant   <= ID_W'(N_MASTERS - 1);
    end else begin
      m_ack <= '0;
      m_err <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            cpu_general  <= pick;
            addr_general <= m_addr[int'(pick)*ADDR_W +: ADDR_W];
            be_general   <= m_be[int'(pick)*BE_W +: BE_W];
            dwr_general  <= m_dwr[int'(pick)*DATA_W +: DATA_W];
            wr_general   <= m_wr[pick];
            // A simultaneous write+read is treated as a write.
            rd_general   <= m_rd[pick] & ~m_wr[pick];
            cnt          <= '0;
          end
        end
        BUSY: begin
          if (ack_slave || expired) begin
            wr_general         <= 1'b0;
            rd_general         <= 1'b0;
            m_ack[cpu_general] <= 1'b1;
            m_err[cpu_general] <= ~ack_slave;
            m_drd[int'(cpu_general)*DATA_W +: DATA_W] <=
              (ack_slave && rd_general) ? drd_general : '0;
            last_grant         <= cpu_general;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
